// File: rtl/apb_master_bridge.sv
// APB initiator: single-beat valid/ready commands become APB SETUP/ACCESS transfers.
// Optional build macro APB_MASTER_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES wait states.
module apb_master_bridge #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr,
    input  logic                      req_write,
    input  logic [31:0]               req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                    state_q;
    logic                      req_ready_q;
    logic                      rsp_valid_q;
    logic [31:0]               rsp_rdata_q;
    logic                      rsp_err_q;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic [31:0]               pwdata_q;
    logic                      pwrite_q;
    logic                      psel_q;
    logic                      penable_q;
    logic                      timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;

    // A wait cycle seen while the counter already holds LAST is the TIMEOUT_CYCLES-th one.
    assign timeout_hit = (wait_cnt_q == CNT_LAST);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ST_IDLE && req_valid) begin
            wait_cnt_d = '0;
        end else if (state_q == ST_ACCESS && !PREADY && !timeout_hit) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= 32'd0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        paddr_q     <= req_addr;
                        pwdata_q    <= req_wdata;
                        pwrite_q    <= req_write;
                        psel_q      <= 1'b1;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // PREADY wins over a timeout reached in the same cycle.
                    if (PREADY) begin
                        rsp_rdata_q <= pwrite_q ? 32'd0 : PRDATA;
                        rsp_err_q   <= PSLVERR;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= ST_RESP;
                    end else if (timeout_hit) begin
                        rsp_rdata_q <= 32'hDEAD_BEEF;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed transfers, scoreboard queue checked by a response monitor.
// Build with APB_MASTER_TIMEOUT_EN defined to also exercise the ACCESS timeout.
module tb_apb_master_bridge;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 256;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    apb_master_bridge #(
        .APB_ADDR_WIDTH(12),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_rsp = 0;
    int   cyc   = 0;

    // Slave model configuration
    int          wait_cfg   = 0;
    logic [31:0] prdata_cfg = 32'd0;
    logic        slverr_cfg = 1'b0;
    logic        noise_cfg  = 1'b0;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // APB slave: PREADY after wait_cfg low ACCESS cycles; with noise_cfg, junk outside completion.
    initial begin : slave
        int acc_n;
        acc_n   = 0;
        PREADY  = 1'b0;
        PRDATA  = 32'd0;
        PSLVERR = 1'b0;
        forever begin
            @(posedge HCLK);
            #1;
            if (PSEL && PENABLE) begin
                PREADY = (acc_n >= wait_cfg);
                acc_n++;
            end else begin
                acc_n  = 0;
                PREADY = noise_cfg;
            end
            PRDATA  = (PREADY && PSEL && PENABLE) ? prdata_cfg : (noise_cfg ? 32'hFFFF_FFFF : 32'd0);
            PSLVERR = (PREADY && PSEL && PENABLE) ? slverr_cfg : noise_cfg;
        end
    end

    // Response monitor: the handshake completes at the next posedge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (!HRESET && rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got rdata=0x%08h err=%0b, required no response",
                             rsp_rdata, rsp_err);
                end else begin
                    e = sb_q.pop_front();
                    n_rsp++;
                    $display("rsp %0d: rdata=0x%08h err=%0b (expected 0x%08h err=%0b)",
                             n_rsp, rsp_rdata, rsp_err, e.rdata, e.err);
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // One transfer; called at posedge+1 with the DUT in IDLE.
    task automatic run_xfer(input string name, input logic [11:0] addr, input logic wr,
                            input logic [31:0] wdata, input int waits, input logic [31:0] prdata,
                            input logic slverr, input logic noise, input int bp,
                            input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        int   t;
        int   n;
        int   psel_at;
        int   pen_at;
        int   rsp_at;
        int   bad;
        exp_t e;
        wait_cfg   = waits;
        prdata_cfg = prdata;
        slverr_cfg = slverr;
        noise_cfg  = noise;
        e.rdata    = exp_rdata;
        e.err      = exp_err;
        sb_q.push_back(e);
        rsp_ready  = (bp == 0);
        req_addr   = addr;
        req_write  = wr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        t = 0;
        while (!req_ready && t < 50) begin
            @(posedge HCLK);
            #1;
            t++;
        end
        chk({name, "_accept_wait"}, {31'd0, (t >= 50)}, 32'd0);
        @(posedge HCLK);
        #1;
        n = cyc;
        req_valid = 1'b0;
        req_addr  = ~addr;
        req_wdata = ~wdata;
        req_write = ~wr;
        chk({name, "_req_ready_busy"}, {31'd0, req_ready}, 32'd0);
        psel_at = -1;
        pen_at  = -1;
        rsp_at  = -1;
        bad     = 0;
        for (int k = 0; k < 40; k++) begin
            if (PSEL && psel_at < 0) begin
                psel_at = cyc - n + 1;
                if (PENABLE) bad++;
            end
            if (PENABLE && pen_at < 0) pen_at = cyc - n + 1;
            if (PENABLE && !PSEL) bad++;
            if (PSEL && (PADDR !== addr || PWDATA !== wdata || PWRITE !== wr)) bad++;
            if (rsp_valid) begin
                rsp_at = cyc - n + 1;
                break;
            end
            @(posedge HCLK);
            #1;
        end
        chk({name, "_psel_lat"}, psel_at, 1);
        chk({name, "_penable_lat"}, pen_at, 2);
        chk({name, "_rsp_lat"}, rsp_at, exp_lat);
        chk({name, "_apb_stable"}, bad, 0);
        chk({name, "_paddr_hold"}, {20'd0, PADDR}, {20'd0, addr});
        for (int i = 0; i < bp; i++) begin
            chk({name, "_bp_valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({name, "_bp_rdata"}, rsp_rdata, exp_rdata);
            chk({name, "_bp_busy"}, {30'd0, req_ready, PSEL}, 32'd0);
            @(posedge HCLK);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge HCLK);
        #1;
        chk({name, "_idle_after"}, {29'd0, req_ready, rsp_valid, PSEL}, 32'd4);
    endtask

    initial begin : stim
        int t;
        int seen;
        HRESET    = 1'b1;
        req_valid = 1'b0;
        req_addr  = 12'd0;
        req_write = 1'b0;
        req_wdata = 32'd0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("reset_ctrl", {27'd0, req_ready, PSEL, PENABLE, PWRITE, rsp_valid}, 32'h10);
        chk("reset_err", {31'd0, rsp_err}, 32'd0);
        chk("reset_paddr", {20'd0, PADDR}, 32'd0);
        chk("reset_pwdata", PWDATA, 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;

        run_xfer("wr0", 12'h008, 1'b1, 32'hA5A5_0F0F, 0, 32'hCAFE_0000, 1'b0, 1'b0, 0,
                 32'd0, 1'b0, 3);
        run_xfer("rd3w", 12'h010, 1'b0, 32'd0, 3, 32'h1234_5678, 1'b0, 1'b1, 0,
                 32'h1234_5678, 1'b0, 6);
        run_xfer("rderr", 12'h018, 1'b0, 32'd0, 0, 32'h0BAD_0018, 1'b1, 1'b0, 0,
                 32'h0BAD_0018, 1'b1, 3);
        run_xfer("wrclean", 12'h01C, 1'b1, 32'h1122_3344, 1, 32'h7777_7777, 1'b0, 1'b0, 0,
                 32'd0, 1'b0, 4);
        run_xfer("bp5", 12'h020, 1'b0, 32'd0, 0, 32'h55AA_33CC, 1'b0, 1'b0, 5,
                 32'h55AA_33CC, 1'b0, 3);

        // Reset in the second ACCESS wait cycle; that response must never appear.
        wait_cfg   = 100;
        noise_cfg  = 1'b0;
        rsp_ready  = 1'b1;
        req_addr   = 12'h040;
        req_write  = 1'b0;
        req_valid  = 1'b1;
        @(posedge HCLK);
        #1;
        req_valid = 1'b0;
        t = 0;
        while (!(PSEL && PENABLE) && t < 20) begin
            @(posedge HCLK);
            #1;
            t++;
        end
        chk("rst_reach_access", {31'd0, (t >= 20)}, 32'd0);
        @(posedge HCLK);
        #1;
        chk("rst_still_waiting", {30'd0, PENABLE, rsp_valid}, 32'd2);
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        chk("rst_mid_ctrl", {28'd0, req_ready, PSEL, PENABLE, rsp_valid}, 32'h8);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid || PSEL) seen++;
            @(posedge HCLK);
            #1;
        end
        chk("rst_no_rsp", seen, 0);

        run_xfer("post_rst", 12'h044, 1'b0, 32'd0, 2, 32'h0F0F_1234, 1'b0, 1'b1, 0,
                 32'h0F0F_1234, 1'b0, 5);

`ifdef APB_MASTER_TIMEOUT_EN
        run_xfer("timeout", 12'h030, 1'b0, 32'd0, 1000, 32'h1111_2222, 1'b0, 1'b0, 0,
                 32'hDEAD_BEEF, 1'b1, 6);
        run_xfer("after_to", 12'h034, 1'b1, 32'h0000_BEEF, 0, 32'd0, 1'b0, 1'b0, 0,
                 32'd0, 1'b0, 3);
`endif

        repeat (3) @(posedge HCLK);
        #1;
        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
